// File: rtl/line_pkg.sv
// Shared types for the line sequencer: state encoding, line endpoint record and the fixed line table.
// Pure declarations; no latency or backpressure of its own.
package line_pkg;

  localparam int X_W       = 10;
  localparam int Y_W       = 9;
  localparam int TABLE_LEN = 6;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    DRAW,
    DONE
  } seq_state_t;

  typedef struct packed {
    logic [X_W-1:0] x0;
    logic [Y_W-1:0] y0;
    logic [X_W-1:0] x1;
    logic [Y_W-1:0] y1;
  } line_t;

  // Stored unclipped; y=480 lies below the screen and is dropped at the write port.
  localparam line_t LINE_TABLE [TABLE_LEN] = '{
    '{x0: 10'd160, y0: 9'd240, x1: 10'd480, y1: 9'd240},
    '{x0: 10'd320, y0: 9'd120, x1: 10'd320, y1: 9'd360},
    '{x0: 10'd240, y0: 9'd240, x1: 10'd480, y1: 9'd480},
    '{x0: 10'd240, y0: 9'd480, x1: 10'd480, y1: 9'd240},
    '{x0: 10'd0,   y0: 9'd0,   x1: 10'd240, y1: 9'd480},
    '{x0: 10'd0,   y0: 9'd0,   x1: 10'd480, y1: 9'd240}
  };

  // Indices beyond the stored table read back as a zero-length line at the origin.
  function automatic line_t table_entry(input logic [3:0] idx);
    line_t r;
    r = '0;
    for (int i = 0; i < TABLE_LEN; i++) begin
      if (idx == 4'(i)) r = LINE_TABLE[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/screen_clear_counter.sv
// Raster x/y walker over the visible screen; position advances one step per enabled cycle.
// Latency: position is registered, last is combinational from it; no backpressure beyond en.
module screen_clear_counter
  import line_pkg::*;
#(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clr,
  input  logic           en,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);

  localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - 1);

  logic x_wrap;

  assign x_wrap = (x == X_MAX);
  assign last   = x_wrap && (y == Y_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x <= '0;
      y <= '0;
    end else if (clr) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (x_wrap) begin
        x <= '0;
        y <= last ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/line_sequencer.sv
// Runs an optional screen clear, then hands each table line to the drawer and forwards its pixels, clipped.
// Latency: endpoints/line_start one cycle after LOAD, pixels pass through combinationally; waits on line_done.
module line_sequencer
  import line_pkg::*;
#(
  parameter int NUM_LINES = 6,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       clear_first,
  output logic [9:0] x0,
  output logic [8:0] y0,
  output logic [9:0] x1,
  output logic [8:0] y1,
  output logic       line_start,
  input  logic [9:0] drw_x,
  input  logic [8:0] drw_y,
  input  logic       drw_valid,
  input  logic       line_done,
  output logic [9:0] fb_x,
  output logic [8:0] fb_y,
  output logic       fb_write,
  output logic       fb_color,
  output logic [3:0] line_idx,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0]     LAST_IDX = 4'(NUM_LINES - 1);
  localparam logic [X_W-1:0] X_LIM    = X_W'(SCREEN_W);
  localparam logic [Y_W-1:0] Y_LIM    = Y_W'(SCREEN_H);

  seq_state_t     state, state_nxt;
  logic [X_W-1:0] clr_x;
  logic [Y_W-1:0] clr_y;
  logic           clr_last;
  logic           clr_hold;
  logic           clr_en;
  line_t          entry;

  // Counter is parked at the origin whenever no sweep is in progress.
  assign clr_hold = (state != CLEAR);
  assign clr_en   = (state == CLEAR);
  assign entry    = table_entry(line_idx);

  screen_clear_counter #(
    .SCREEN_W(SCREEN_W),
    .SCREEN_H(SCREEN_H)
  ) u_clear (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (clr_hold),
    .en     (clr_en),
    .x      (clr_x),
    .y      (clr_y),
    .last   (clr_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fb_x      = '0;
    fb_y      = '0;
    fb_write  = 1'b0;
    fb_color  = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = clear_first ? CLEAR : LOAD;
      end
      CLEAR: begin
        fb_x     = clr_x;
        fb_y     = clr_y;
        fb_write = 1'b1;
        if (clr_last) state_nxt = LOAD;
      end
      LOAD: state_nxt = DRAW;
      DRAW: begin
        fb_x     = drw_x;
        fb_y     = drw_y;
        fb_color = 1'b1;
        fb_write = drw_valid && (drw_x < X_LIM) && (drw_y < Y_LIM);
        if (line_done) state_nxt = (line_idx == LAST_IDX) ? DONE : LOAD;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x0         <= '0;
      y0         <= '0;
      x1         <= '0;
      y1         <= '0;
      line_start <= 1'b0;
      line_idx   <= '0;
    end else begin
      line_start <= (state == LOAD);
      if (state == LOAD) begin
        x0 <= entry.x0;
        y0 <= entry.y0;
        x1 <= entry.x1;
        y1 <= entry.y1;
      end
      if (state == IDLE && start) begin
        line_idx <= '0;
      end else if (state == DRAW && line_done && line_idx != LAST_IDX) begin
        line_idx <= line_idx + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_line_sequencer.sv
// Randomized bench for line_sequencer on a reduced screen; expectations come from the line table,
// raster arithmetic and the clip rule.
module tb_line_sequencer;

  localparam int NL = 6;
  localparam int W  = 64;
  localparam int H  = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       clear_first = 1'b0;
  logic [9:0] x0, x1;
  logic [8:0] y0, y1;
  logic       line_start;
  logic [9:0] drw_x = '0;
  logic [8:0] drw_y = '0;
  logic       drw_valid = 1'b0;
  logic       line_done = 1'b0;
  logic [9:0] fb_x;
  logic [8:0] fb_y;
  logic       fb_write, fb_color;
  logic [3:0] line_idx;
  logic       busy, done;

  int checks = 0;
  int errors = 0;

  int ref_tbl [NL][4] = '{
    '{160, 240, 480, 240},
    '{320, 120, 320, 360},
    '{240, 240, 480, 480},
    '{240, 480, 480, 240},
    '{0,   0,   240, 480},
    '{0,   0,   480, 240}
  };

  always #5 clk = ~clk;

  line_sequencer #(.NUM_LINES(NL), .SCREEN_W(W), .SCREEN_H(H)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .clear_first(clear_first),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .line_start(line_start),
    .drw_x(drw_x), .drw_y(drw_y), .drw_valid(drw_valid), .line_done(line_done),
    .fb_x(fb_x), .fb_y(fb_y), .fb_write(fb_write), .fb_color(fb_color),
    .line_idx(line_idx), .busy(busy), .done(done)
  );

  task automatic nxt();
    @(negedge clk);
  endtask

  function automatic bit on_screen(int x, int y);
    return (x < W) && (y < H);
  endfunction

  function automatic logic [37:0] exp_ep(int k);
    return {10'(ref_tbl[k][0]), 9'(ref_tbl[k][1]), 10'(ref_tbl[k][2]), 9'(ref_tbl[k][3])};
  endfunction

  function automatic logic [65:0] outs();
    return {x0, y0, x1, y1, line_start, fb_x, fb_y, fb_write, fb_color, line_idx, busy, done};
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    nxt(); #1;
    checks++;
    if (outs() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", outs());
    end
    reset_n = 1'b1;
  endtask

  task automatic test_first_line();
    int px[$];
    int py[$];
    bit exp_w;
    px = '{10, 700, 20, W-1, W, 0};
    py = '{10, 5, 500, H-1, 0, H};
    for (int i = 0; i < 4; i++) begin
      px.push_back(int'($urandom_range(0, 1023)));
      py.push_back(int'($urandom_range(0, 511)));
    end
    nxt(); start = 1'b1; clear_first = 1'b0; #1;
    nxt(); start = 1'b0; #1;
    checks++;
    if ({busy, line_start, fb_write} !== 3'b100) begin
      errors++;
      $display("FAIL load_cycle: busy/line_start/fb_write got %b want 100", {busy, line_start, fb_write});
    end
    nxt(); #1;
    checks++;
    if ({line_start, busy, line_idx, x0, y0, x1, y1} !== {1'b1, 1'b1, 4'd0, exp_ep(0)}) begin
      errors++;
      $display("FAIL line0_start: start=%b idx=%0d ep=(%0d,%0d)->(%0d,%0d) want line 0", line_start, line_idx, x0, y0, x1, y1);
    end
    for (int i = 0; i < px.size(); i++) begin
      nxt();
      drw_valid = 1'b1;
      drw_x = 10'(px[i]);
      drw_y = 9'(py[i]);
      line_done = (i == px.size() - 1);
      #1;
      exp_w = on_screen(px[i], py[i]);
      checks++;
      if ({fb_write, fb_color, fb_x, fb_y} !== {exp_w, 1'b1, 10'(px[i]), 9'(py[i])}) begin
        errors++;
        $display("FAIL clip_pixel%0d: got we=%b c=%b (%0d,%0d) want we=%b c=1 (%0d,%0d)", i, fb_write, fb_color, fb_x, fb_y, exp_w, px[i], py[i]);
      end
    end
    nxt(); drw_valid = 1'b0; line_done = 1'b0; #1;
    checks++;
    if ({fb_write, line_start, busy} !== 3'b001) begin
      errors++;
      $display("FAIL after_done_load: we/ls/busy got %b want 001", {fb_write, line_start, busy});
    end
    nxt(); #1;
    checks++;
    if ({line_start, line_idx, x0, y0, x1, y1} !== {1'b1, 4'd1, exp_ep(1)}) begin
      errors++;
      $display("FAIL line1_start: start=%b idx=%0d ep=(%0d,%0d)->(%0d,%0d) want line 1", line_start, line_idx, x0, y0, x1, y1);
    end
  endtask

  task automatic test_abort_draw();
    nxt(); drw_valid = 1'b1; drw_x = 10'd5; drw_y = 9'd5; #1;
    checks++;
    if (fb_write !== 1'b1) begin
      errors++;
      $display("FAIL draw_before_abort: fb_write got %b want 1", fb_write);
    end
    reset_n = 1'b0; #1;
    checks++;
    if (outs() !== '0) begin
      errors++;
      $display("FAIL abort_draw_async: got %h want 0", outs());
    end
    nxt(); reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      nxt(); drw_valid = i[0]; line_done = i[1]; #1;
      checks++;
      if ({fb_write, line_start, busy} !== 3'b000) begin
        errors++;
        $display("FAIL after_abort_draw%0d: we/ls/busy got %b want 000", i, {fb_write, line_start, busy});
      end
    end
    drw_valid = 1'b0; line_done = 1'b0;
  endtask

  task automatic test_full_run();
    int n_start = 0, n_done = 0, budget = 0, pix_left = 0, post = 0;
    bit drawing = 0, seen_done = 0, was_drawing, exp_w;
    nxt(); start = 1'b1; clear_first = 1'b0; #1;
    nxt(); start = 1'b0;
    while (budget < 2000 && post < 4) begin
      drw_valid = 1'b0; line_done = 1'b0; start = 1'b0;
      was_drawing = drawing;
      if (drawing) begin
        if (pix_left > 0) begin
          drw_valid = 1'b1;
          drw_x = 10'($urandom_range(0, W + 8));
          drw_y = 9'($urandom_range(0, H + 8));
          pix_left--;
        end
        if (pix_left == 0) begin
          line_done = 1'b1;
          drawing = 0;
        end
        if (n_start == 3) start = 1'b1;
      end
      #1;
      exp_w = was_drawing && drw_valid && on_screen(int'(drw_x), int'(drw_y));
      checks++;
      if (fb_write !== exp_w) begin
        errors++;
        $display("FAIL run_write: at (%0d,%0d) v=%b got %b want %b", drw_x, drw_y, drw_valid, fb_write, exp_w);
      end
      if (line_start) begin
        checks++;
        if (n_start >= NL || {line_idx, x0, y0, x1, y1} !== {4'(n_start), exp_ep(n_start)}) begin
          errors++;
          $display("FAIL run_line%0d: idx=%0d ep=(%0d,%0d)->(%0d,%0d)", n_start, line_idx, x0, y0, x1, y1);
        end
        n_start++;
        drawing = 1;
        pix_left = int'($urandom_range(0, 3));
      end
      if (done) begin
        n_done++;
        seen_done = 1;
        checks++;
        if ({line_idx, busy} !== {4'(NL - 1), 1'b1}) begin
          errors++;
          $display("FAIL done_state: idx=%0d busy=%b want idx=%0d busy=1", line_idx, busy, NL - 1);
        end
      end
      if (seen_done) post++;
      nxt();
      budget++;
    end
    #1;
    checks++;
    if (n_start != NL || n_done != 1 || !seen_done) begin
      errors++;
      $display("FAIL run_counts: line_start=%0d done=%0d want %0d and 1", n_start, n_done, NL);
    end
    checks++;
    if ({busy, line_idx} !== {1'b0, 4'(NL - 1)}) begin
      errors++;
      $display("FAIL run_end: busy=%b idx=%0d want busy=0 idx=%0d", busy, line_idx, NL - 1);
    end
  endtask

  task automatic test_idle_ignore();
    for (int i = 0; i < 20; i++) begin
      nxt();
      drw_valid = 1'($urandom_range(0, 1));
      line_done = 1'($urandom_range(0, 1));
      drw_x = 10'($urandom_range(0, W - 1));
      drw_y = 9'($urandom_range(0, H - 1));
      #1;
      checks++;
      if ({fb_write, busy, line_start, done, line_idx} !== {4'b0000, 4'(NL - 1)}) begin
        errors++;
        $display("FAIL idle_ignore%0d: we/busy/ls/done=%b idx=%0d want 0000 idx=%0d", i, {fb_write, busy, line_start, done}, line_idx, NL - 1);
      end
    end
    drw_valid = 1'b0; line_done = 1'b0;
  endtask

  task automatic test_clear();
    nxt(); start = 1'b1; clear_first = 1'b1; #1;
    nxt(); start = 1'b0; clear_first = 1'b0; #1;
    for (int i = 0; i < W * H; i++) begin
      checks++;
      if ({fb_write, fb_color, fb_x, fb_y} !== {2'b10, 10'(i % W), 9'(i / W)}) begin
        errors++;
        $display("FAIL clear_px%0d: we=%b c=%b (%0d,%0d) want we=1 c=0 (%0d,%0d)", i, fb_write, fb_color, fb_x, fb_y, i % W, i / W);
      end
      nxt(); #1;
    end
    checks++;
    if ({fb_write, line_start, busy} !== 3'b001) begin
      errors++;
      $display("FAIL clear_to_load: we/ls/busy got %b want 001", {fb_write, line_start, busy});
    end
    nxt(); #1;
    checks++;
    if ({line_start, line_idx, x0, y0, x1, y1} !== {1'b1, 4'd0, exp_ep(0)}) begin
      errors++;
      $display("FAIL clear_line0: start=%b idx=%0d ep=(%0d,%0d)->(%0d,%0d) want line 0", line_start, line_idx, x0, y0, x1, y1);
    end
  endtask

  task automatic test_abort_clear();
    reset_n = 1'b0;
    nxt(); reset_n = 1'b1;
    nxt(); start = 1'b1; clear_first = 1'b1; #1;
    nxt(); start = 1'b0; clear_first = 1'b0;
    for (int i = 0; i < 3 * W + 10; i++) nxt();
    #1;
    checks++;
    if ({fb_write, fb_x, fb_y} !== {1'b1, 10'd10, 9'd3}) begin
      errors++;
      $display("FAIL clear_pos: we=%b (%0d,%0d) want we=1 (10,3)", fb_write, fb_x, fb_y);
    end
    reset_n = 1'b0; #1;
    checks++;
    if (outs() !== '0) begin
      errors++;
      $display("FAIL abort_clear_async: got %h want 0", outs());
    end
    nxt(); reset_n = 1'b1;
    for (int i = 0; i < 2 * W; i++) begin
      nxt(); #1;
      checks++;
      if ({fb_write, busy, line_start} !== 3'b000) begin
        errors++;
        $display("FAIL after_abort_clear%0d: we/busy/ls got %b want 000", i, {fb_write, busy, line_start});
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_abort_draw();
    test_full_run();
    test_idle_ignore();
    test_clear();
    test_abort_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/line_sequencer.md
Name: line_sequencer

Overview:
- Initiator side of the line-drawing interface: the pixel-producing line drawer responds to this block.
- On a start pulse, it optionally clears the framebuffer with a raster sweep.
- It then issues the endpoints of each entry in a fixed line table to the line drawer, one at a time, with a start/done handshake.
- It forwards the drawer's pixels to the framebuffer write port, clipped to the screen. It sits between the top level and the framebuffer, replacing hard-wired endpoint assigns.

Parameters:
- NUM_LINES, 6, number of entries in the line table (1..16).
- SCREEN_W, 640, visible width; valid x is 0..SCREEN_W-1.
- SCREEN_H, 480, visible height; valid y is 0..SCREEN_H-1.

Ports:
- clk  in  1  system clock (50 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to run the sequence; sampled only in IDLE.
- clear_first  in  1  sampled with start; 1 = sweep-clear before drawing.
- x0, x1  out  10  current line endpoints x, to the drawer.
- y0, y1  out  9  current line endpoints y, to the drawer.
- line_start  out  1  one-cycle pulse; endpoints are valid and held from this cycle until line_done.
- drw_x  in  10  drawer pixel x.
- drw_y  in  9  drawer pixel y.
- drw_valid  in  1  drawer pixel valid this cycle.
- line_done  in  1  one-cycle pulse from the drawer after its last pixel.
- fb_x  out  10  framebuffer write x.
- fb_y  out  9  framebuffer write y.
- fb_write  out  1  framebuffer write enable.
- fb_color  out  1  framebuffer pixel colour.
- line_idx  out  4  index of the current or last line.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the sequence completes.

Behaviour:
- Reset: async assert forces IDLE. All outputs are 0: x0/y0/x1/y1, line_start, fb_*, line_idx, busy, done. Clear counters are 0.
- Reset mid-operation aborts immediately. No further fb_write and no line_start occur until a new start after release.
- IDLE:
  - start=1 with clear_first=1 -> CLEAR.
  - start=1 with clear_first=0 -> LOAD.
  - line_idx is set to 0 on either transition.
  - drw_valid and line_done are ignored in IDLE.
- CLEAR:
  - fb_write=1 and fb_color=0 every cycle.
  - (fb_x, fb_y) walks raster order from (0,0): x increments, wraps at SCREEN_W-1 to 0, and y increments on the wrap.
  - The cycle at (SCREEN_W-1, SCREEN_H-1) is the last write; the next state is LOAD.
  - Duration is exactly SCREEN_W*SCREEN_H cycles (307200 at defaults).
- LOAD:
  - x0/y0/x1/y1 are registered from table[line_idx] and line_start=1 for this single cycle -> DRAW.
  - Endpoints stay stable until the next LOAD.
- DRAW:
  - Each cycle: fb_x=drw_x, fb_y=drw_y, fb_color=1.
  - fb_write = drw_valid and (drw_x < SCREEN_W) and (drw_y < SCREEN_H). Off-screen pixels are dropped silently.
  - Combinational pass-through; zero latency.
  - On line_done:
    - If line_idx == NUM_LINES-1 -> DONE.
    - Otherwise line_idx increments and the next state is LOAD.
  - If drw_valid and line_done occur in the same cycle, the pixel is still written.
- DONE: done=1 for one cycle -> IDLE. line_idx holds NUM_LINES-1.
- start while busy is ignored; it is not queued.
- Outside CLEAR and DRAW, fb_write=0 and fb_x/fb_y/fb_color are 0.
- Line table, entries 0..5 as (x0,y0)->(x1,y1):
  - 0: (160,240)->(480,240)
  - 1: (320,120)->(320,360)
  - 2: (240,240)->(480,480)
  - 3: (240,480)->(480,240)
  - 4: (0,0)->(240,480)
  - 5: (0,0)->(480,240)
- Entries are stored unclipped. y=480 exceeds SCREEN_H-1 and is handled by the write clip; the 9-bit y fields hold 480 without overflow.

Decomposition:
- Package line_pkg contains:
  - seq_state_t enum: IDLE, CLEAR, LOAD, DRAW, DONE.
  - line_t struct: x0, y0, x1, y1.
  - constants X_W=10, Y_W=9.
  - LINE_TABLE constant array.
- Sub-module screen_clear_counter: x/y raster counter with enable and last flag, reused by later fill logic.

Test Plan:
- Reset then start with clear_first=0 -> line_start on the cycle after entering LOAD. Outputs x0=160, y0=240, x1=480, y1=240; line_idx=0; busy=1.
- Drawer model emits 3 pixels (10,10), (700,5), (20,500) with drw_valid, then line_done -> fb_write high only for (10,10). After line_done, the next LOAD shows entry 1: (320,120)->(320,360).
- Full run with an immediate-done drawer model -> exactly 6 line_start pulses, then one done pulse with line_idx=5, then busy=0.
- start with clear_first=1 -> 307200 consecutive fb_write cycles with fb_color=0. The first write is at (0,0), (639,0) is followed by (0,1), and the last write is (639,479); then LOAD.
- Deassert reset_n midway through CLEAR at (100,3) -> all outputs 0 asynchronously. After release there is no fb_write until a new start.
- Pulse start during DRAW, and toggle drw_valid/line_done while in IDLE -> no state change, no fb_write, line_idx unchanged.
